// File: rtl/prog_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : prog_sequencer
//  Purpose  : Runs a batch of NUM_PROGS programs on a processor core, one
//             after another. Each program gets a one-cycle start pulse with
//             its start address taken from a small configurable table. The
//             core reports completion with a rising edge on core_halt. A
//             program that runs for TIMEOUT cycles without halting aborts the
//             rest of the batch.
//
//  Ports    : CLK          - clock, all state changes on the rising edge
//             reset        - asynchronous active-high reset
//             go           - start a batch (ignored while busy)
//             cfg_we       - start-address table write enable (idle only)
//             cfg_idx      - table entry to write
//             cfg_addr     - start address to write
//             core_halt    - halt flag from the core
//             core_start   - one-cycle start pulse to the core
//             core_pc_init - start address of the current program
//             busy         - batch in progress
//             done         - batch finished, sticky until the next go
//             timeout_err  - a program exceeded TIMEOUT, sticky
//             prog_idx     - index of the current / last program
//             cyc_count    - run length of the last completed program
//
//  Revision : 1.0 - initial release
// ============================================================================
module prog_sequencer #(
    parameter int NUM_PROGS = 3,
    parameter int PC_W      = 10,
    parameter int TIMEOUT   = 4096
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            go,
    input  logic            cfg_we,
    input  logic [1:0]      cfg_idx,
    input  logic [PC_W-1:0] cfg_addr,
    input  logic            core_halt,
    output logic            core_start,
    output logic [PC_W-1:0] core_pc_init,
    output logic            busy,
    output logic            done,
    output logic            timeout_err,
    output logic [1:0]      prog_idx,
    output logic [15:0]     cyc_count
);

    localparam logic [1:0]  c_st_idle   = 2'd0;
    localparam logic [1:0]  c_st_launch = 2'd1;
    localparam logic [1:0]  c_st_run    = 2'd2;
    localparam logic [1:0]  c_st_done   = 2'd3;

    localparam logic [15:0] c_timeout   = 16'(TIMEOUT);
    localparam logic [15:0] c_cnt_max   = 16'hFFFF;
    localparam logic [1:0]  c_last_idx  = 2'(NUM_PROGS - 1);

    logic [1:0]         r_state;
    logic [15:0]        r_run_cnt;
    logic               r_halt_q;
    logic               r_core_start;
    logic               r_busy;
    logic               r_done;
    logic               r_timeout_err;
    logic [1:0]         r_prog_idx;
    logic [15:0]        r_cyc_count;

    // All four possible table slots flattened; slots beyond NUM_PROGS read 0.
    logic [4*PC_W-1:0]  w_table_flat;
    logic               w_halt_rise;
    logic               w_at_limit;
    logic               w_is_last;

    // ------------------------------------------------------------------
    // Start-address table. Writes are blocked while a batch is running so
    // the addresses of a batch cannot change under it; indices with no
    // backing entry simply match nothing.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_entry
        if (gi < NUM_PROGS) begin : g_used
            logic [PC_W-1:0] r_entry;

            always_ff @(posedge CLK or posedge reset) begin
                if (reset) begin
                    r_entry <= '0;
                end else if (cfg_we && !r_busy && (cfg_idx == 2'(gi))) begin
                    r_entry <= cfg_addr;
                end
            end

            assign w_table_flat[gi*PC_W +: PC_W] = r_entry;
        end else begin : g_unused
            assign w_table_flat[gi*PC_W +: PC_W] = '0;
        end
    end

    // Only a fresh 0->1 transition counts as completion, so a halt level
    // still asserted from the previous program cannot finish the next one.
    assign w_halt_rise = core_halt && !r_halt_q;
    assign w_at_limit  = (r_run_cnt == c_timeout);
    assign w_is_last   = (r_prog_idx == c_last_idx);

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state       <= c_st_idle;
            r_run_cnt     <= '0;
            r_halt_q      <= 1'b0;
            r_core_start  <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_prog_idx    <= '0;
            r_cyc_count   <= '0;
        end else begin
            // Sampled every cycle: the value seen during LAUNCH is what the
            // first RUN cycle compares against.
            r_halt_q     <= core_halt;
            r_core_start <= 1'b0;

            case (r_state)
                c_st_idle, c_st_done: begin
                    if (go) begin
                        r_state       <= c_st_launch;
                        r_core_start  <= 1'b1;
                        r_prog_idx    <= '0;
                        r_done        <= 1'b0;
                        r_timeout_err <= 1'b0;
                        r_busy        <= 1'b1;
                    end
                end

                c_st_launch: begin
                    r_state   <= c_st_run;
                    r_run_cnt <= 16'd1;
                end

                c_st_run: begin
                    if (r_run_cnt != c_cnt_max) begin
                        r_run_cnt <= r_run_cnt + 16'd1;
                    end

                    // Completion is checked first so a halt arriving on the
                    // very cycle the limit is reached still counts as success.
                    if (w_halt_rise) begin
                        r_cyc_count <= r_run_cnt;
                        if (w_is_last) begin
                            r_state <= c_st_done;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_prog_idx   <= r_prog_idx + 2'd1;
                            r_state      <= c_st_launch;
                            r_core_start <= 1'b1;
                        end
                    end else if (w_at_limit) begin
                        r_timeout_err <= 1'b1;
                        r_cyc_count   <= c_timeout;
                        r_state       <= c_st_done;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                    end
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign core_start   = r_core_start;
    assign core_pc_init = w_table_flat[int'(r_prog_idx)*PC_W +: PC_W];
    assign busy         = r_busy;
    assign done         = r_done;
    assign timeout_err  = r_timeout_err;
    assign prog_idx     = r_prog_idx;
    assign cyc_count    = r_cyc_count;

endmodule
`default_nettype wire

// File: tb/tb_prog_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_sequencer
//  Purpose  : Scoreboard bench for prog_sequencer. Two instances share one
//             clock: u0 with the default TIMEOUT and u1 with TIMEOUT=16.
//             Stimulus pushes the expected start pulses and batch results
//             into per-instance queues; a monitor pops and compares each
//             time an instance pulses core_start or raises done.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prog_sequencer;

    typedef struct {
        int kind;   // 0 = core_start pulse, 1 = done rising
        int pc;
        int idx;
        int cyc;    // -1 = not checked
        int lat;    // cycles since previous start, -1 = not checked
        int terr;
    } exp_t;

    logic        CLK = 1'b0;
    logic        reset;
    logic        go        [2];
    logic        cfg_we    [2];
    logic [1:0]  cfg_idx;
    logic [9:0]  cfg_addr;
    logic        core_halt [2];
    logic        core_start[2];
    logic [9:0]  pc_init   [2];
    logic        busy      [2];
    logic        done      [2];
    logic        terr      [2];
    logic [1:0]  pidx      [2];
    logic [15:0] cycc      [2];

    int   n_vec  = 0;
    int   n_err  = 0;
    int   cyc_no = 0;
    exp_t sbq [2][$];
    int   dly  [2][4];
    int   hold [2][4];
    int   batch[2];

    always #5 CLK = ~CLK;

    prog_sequencer #(.NUM_PROGS(3), .PC_W(10), .TIMEOUT(4096)) u0 (
        .CLK(CLK), .reset(reset), .go(go[0]), .cfg_we(cfg_we[0]),
        .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .core_halt(core_halt[0]),
        .core_start(core_start[0]), .core_pc_init(pc_init[0]),
        .busy(busy[0]), .done(done[0]), .timeout_err(terr[0]),
        .prog_idx(pidx[0]), .cyc_count(cycc[0])
    );

    prog_sequencer #(.NUM_PROGS(3), .PC_W(10), .TIMEOUT(16)) u1 (
        .CLK(CLK), .reset(reset), .go(go[1]), .cfg_we(cfg_we[1]),
        .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .core_halt(core_halt[1]),
        .core_start(core_start[1]), .core_pc_init(pc_init[1]),
        .busy(busy[1]), .done(done[1]), .timeout_err(terr[1]),
        .prog_idx(pidx[1]), .cyc_count(cycc[1])
    );

    task automatic chk(input int u, input string nm, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL u%0d %s: actual %0d required %0d", u, nm, act, req);
        end
    endtask

    task automatic push_start(input int u, input int pc, input int idx,
                              input int cyc, input int lat);
        exp_t e;
        e.kind = 0; e.pc = pc; e.idx = idx; e.cyc = cyc; e.lat = lat; e.terr = 0;
        sbq[u].push_back(e);
    endtask

    task automatic push_done(input int u, input int idx, input int cyc,
                             input int t_err, input int lat);
        exp_t e;
        e.kind = 1; e.pc = 0; e.idx = idx; e.cyc = cyc; e.lat = lat; e.terr = t_err;
        sbq[u].push_back(e);
    endtask

    // Halt-time profile per program; 0 = never halts. A new batch id makes
    // the core model restart its program count.
    task automatic set_prog(input int u, input int d0, input int d1, input int d2);
        dly[u][0] = d0; dly[u][1] = d1; dly[u][2] = d2; dly[u][3] = 0;
        for (int i = 0; i < 4; i++) hold[u][i] = 0;
        batch[u]++;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_go(input int u);
        step();
        go[u] = 1'b1;
        step();
        go[u] = 1'b0;
    endtask

    task automatic write_cfg(input int u, input int idx, input int addr);
        step();
        cfg_we[u] = 1'b1;
        cfg_idx   = 2'(idx);
        cfg_addr  = 10'(addr);
        step();
        cfg_we[u] = 1'b0;
    endtask

    task automatic load_table(input int u, input int a0, input int a1, input int a2);
        write_cfg(u, 0, a0);
        write_cfg(u, 1, a1);
        write_cfg(u, 2, a2);
    endtask

    task automatic wait_done(input int u, input int budget, input string nm);
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (done[u]) break;
        end
        chk(u, {nm, " done reached"}, int'(done[u]), 1);
    endtask

    task automatic wait_sb(input int u, input int budget, input string nm);
        for (int i = 0; i < budget; i++) begin
            if (sbq[u].size() == 0) break;
            @(negedge CLK);
        end
        chk(u, {nm, " pending events"}, sbq[u].size(), 0);
    endtask

    task automatic check_reset(input string nm);
        for (int u = 0; u < 2; u++) begin
            chk(u, {nm, " core_start"},   int'(core_start[u]), 0);
            chk(u, {nm, " busy"},         int'(busy[u]), 0);
            chk(u, {nm, " done"},         int'(done[u]), 0);
            chk(u, {nm, " timeout_err"},  int'(terr[u]), 0);
            chk(u, {nm, " prog_idx"},     int'(pidx[u]), 0);
            chk(u, {nm, " cyc_count"},    int'(cycc[u]), 0);
            chk(u, {nm, " core_pc_init"}, int'(pc_init[u]), 0);
        end
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            cyc_no++;
        end
    end

    // Core model: halt rises dly cycles after the start pulse and stays high
    // until the next start; a 'hold' program keeps the previous halt level
    // for its first 5 cycles.
    initial begin
        int nstart[2];
        int since [2];
        int seen  [2];
        int k;
        for (int u = 0; u < 2; u++) begin
            nstart[u] = 0; since[u] = 0; seen[u] = 0; core_halt[u] = 1'b0;
        end
        forever begin
            @(negedge CLK);
            for (int u = 0; u < 2; u++) begin
                if (reset) begin
                    nstart[u] = 0;
                    since[u]  = 0;
                    core_halt[u] = 1'b0;
                end else begin
                    if (batch[u] != seen[u]) begin
                        seen[u]   = batch[u];
                        nstart[u] = 0;
                    end
                    if (core_start[u]) begin
                        nstart[u]++;
                        since[u] = 0;
                    end else begin
                        since[u]++;
                    end
                    if (nstart[u] > 0) begin
                        k = (nstart[u] > 4) ? 3 : nstart[u] - 1;
                        core_halt[u] = ((hold[u][k] != 0) && (since[u] < 5)) ||
                                       ((dly[u][k] > 0) && (since[u] >= dly[u][k]));
                    end
                end
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        exp_t e;
        int   last_start[2];
        logic done_q[2];
        for (int u = 0; u < 2; u++) begin
            last_start[u] = 0;
            done_q[u] = 1'b0;
        end
        forever begin
            @(negedge CLK);
            for (int u = 0; u < 2; u++) begin
                if (!reset) begin
                    if (core_start[u]) begin
                        if (sbq[u].size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL u%0d unexpected core_start: actual pc %0d required none",
                                     u, pc_init[u]);
                        end else begin
                            e = sbq[u].pop_front();
                            chk(u, "event kind at start", 0, e.kind);
                            chk(u, "start pc_init", int'(pc_init[u]), e.pc);
                            chk(u, "start prog_idx", int'(pidx[u]), e.idx);
                            chk(u, "start busy", int'(busy[u]), 1);
                            if (e.cyc >= 0) chk(u, "prev cyc_count", int'(cycc[u]), e.cyc);
                            if (e.lat >= 0) chk(u, "start latency", cyc_no - last_start[u], e.lat);
                        end
                        last_start[u] = cyc_no;
                    end
                    if (done[u] && !done_q[u]) begin
                        if (sbq[u].size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL u%0d unexpected done: actual 1 required 0", u);
                        end else begin
                            e = sbq[u].pop_front();
                            chk(u, "event kind at done", 1, e.kind);
                            chk(u, "done cyc_count", int'(cycc[u]), e.cyc);
                            chk(u, "done timeout_err", int'(terr[u]), e.terr);
                            chk(u, "done prog_idx", int'(pidx[u]), e.idx);
                            chk(u, "done busy", int'(busy[u]), 0);
                            chk(u, "done latency", cyc_no - last_start[u], e.lat);
                        end
                    end
                end
                done_q[u] = done[u];
            end
        end
    end

    // Stimulus
    initial begin
        reset = 1'b1;
        cfg_idx = 2'd0;
        cfg_addr = 10'd0;
        for (int u = 0; u < 2; u++) begin
            go[u] = 1'b0;
            cfg_we[u] = 1'b0;
            batch[u] = 0;
            for (int i = 0; i < 4; i++) begin
                dly[u][i] = 0;
                hold[u][i] = 0;
            end
        end
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_reset("power-on");
        step();
        reset = 1'b0;

        // Three programs, halt 20 cycles after each start
        load_table(0, 'h000, 'h040, 'h080);
        load_table(1, 'h000, 'h040, 'h080);
        set_prog(0, 20, 20, 20);
        push_start(0, 'h000, 0, -1, -1);
        push_start(0, 'h040, 1, 20, 21);
        push_start(0, 'h080, 2, 20, 21);
        push_done(0, 2, 20, 0, 21);
        pulse_go(0);
        wait_done(0, 200, "basic");
        repeat (3) step();

        // TIMEOUT=16, program 1 never halts
        set_prog(1, 10, 0, 10);
        push_start(1, 'h000, 0, -1, -1);
        push_start(1, 'h040, 1, 10, 11);
        push_done(1, 1, 16, 1, 17);
        pulse_go(1);
        wait_done(1, 200, "timeout");
        repeat (40) step();
        wait_sb(1, 5, "timeout");

        // go held during the batch; each halt coincides with the limit
        set_prog(1, 16, 16, 16);
        push_start(1, 'h000, 0, -1, -1);
        push_start(1, 'h040, 1, 16, 17);
        push_start(1, 'h080, 2, 16, 17);
        push_done(1, 2, 16, 0, 17);
        step();
        go[1] = 1'b1;
        repeat (45) step();
        go[1] = 1'b0;
        wait_done(1, 100, "go_spam");
        repeat (5) step();
        wait_sb(1, 5, "go_spam");

        // Halt level carried from program 0 into program 1
        set_prog(0, 20, 12, 20);
        hold[0][1] = 1;
        push_start(0, 'h000, 0, -1, -1);
        push_start(0, 'h040, 1, 20, 21);
        push_start(0, 'h080, 2, 12, 13);
        push_done(0, 2, 20, 0, 21);
        pulse_go(0);
        wait_done(0, 200, "sticky_halt");
        repeat (3) step();

        // Table write during RUN is ignored
        set_prog(0, 20, 20, 20);
        push_start(0, 'h000, 0, -1, -1);
        push_start(0, 'h040, 1, 20, 21);
        push_start(0, 'h080, 2, 20, 21);
        push_done(0, 2, 20, 0, 21);
        pulse_go(0);
        repeat (5) step();
        write_cfg(0, 1, 'h3FF);
        wait_done(0, 200, "cfg_in_run");
        repeat (3) step();

        // Table write in DONE takes effect; out-of-range index does nothing
        write_cfg(0, 1, 'h3FF);
        write_cfg(0, 3, 'h155);
        set_prog(0, 20, 20, 20);
        push_start(0, 'h000, 0, -1, -1);
        push_start(0, 'h3FF, 1, 20, 21);
        push_start(0, 'h080, 2, 20, 21);
        push_done(0, 2, 20, 0, 21);
        pulse_go(0);
        wait_done(0, 200, "cfg_in_done");
        repeat (3) step();

        // Reset in the middle of program 2
        set_prog(0, 20, 20, 20);
        push_start(0, 'h000, 0, -1, -1);
        push_start(0, 'h3FF, 1, 20, 21);
        push_start(0, 'h080, 2, 20, 21);
        pulse_go(0);
        wait_sb(0, 200, "pre_reset");
        repeat (6) step();
        @(posedge CLK);
        #3;
        reset = 1'b1;
        #1;
        check_reset("async reset");
        @(negedge CLK);
        check_reset("reset held");
        @(posedge CLK);
        #3;
        reset = 1'b0;
        @(negedge CLK);
        chk(0, "core_start after release", int'(core_start[0]), 0);
        chk(1, "core_start after release", int'(core_start[1]), 0);
        @(negedge CLK);
        chk(0, "core_start 2nd after release", int'(core_start[0]), 0);
        chk(0, "busy after release", int'(busy[0]), 0);

        // Restart after reset begins at program 0
        load_table(0, 'h111, 'h222, 'h333);
        set_prog(0, 20, 20, 20);
        push_start(0, 'h111, 0, -1, -1);
        push_start(0, 'h222, 1, 20, 21);
        push_start(0, 'h333, 2, 20, 21);
        push_done(0, 2, 20, 0, 21);
        pulse_go(0);
        wait_done(0, 200, "restart");

        repeat (5) step();
        wait_sb(0, 10, "final");
        wait_sb(1, 10, "final");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
